// File: rtl/dac_serial_tx_if.sv
// -----------------------------------------------------------------------------
// dac_serial_tx_if
// Groups the request side (start/mode/data) and the DAC pin side
// (SYNC/SCLK/DIN) plus status (busy/tx_done_tick) of the DAC serial
// transmitter.
//
// Signals:
//   start         request one frame (only honoured while the block is idle)
//   mode[1:0]     DAC power-down mode, frame bits [13:12]
//   data[11:0]    DAC sample, frame bits [11:0]
//   SYNC          active-low frame enable to the DAC
//   SCLK          serial clock to the DAC, idles high
//   DIN           serial data, MSB first
//   busy          frame in progress (including the quiet gap)
//   tx_done_tick  one-cycle pulse when SYNC returns high
//
// Modports:
//   master  requester side: drives start/mode/data and observes the rest
//   slave   transmitter side: consumes start/mode/data and drives the rest
// -----------------------------------------------------------------------------
interface dac_serial_tx_if;
  logic        start;
  logic [1:0]  mode;
  logic [11:0] data;
  logic        SYNC;
  logic        SCLK;
  logic        DIN;
  logic        busy;
  logic        tx_done_tick;

  modport master (
    output start, mode, data,
    input  SYNC, SCLK, DIN, busy, tx_done_tick
  );

  modport slave (
    input  start, mode, data,
    output SYNC, SCLK, DIN, busy, tx_done_tick
  );
endinterface

// File: rtl/dac_serial_tx.sv
// -----------------------------------------------------------------------------
// dac_serial_tx
// Serial transmitter for a 12-bit SPI-style DAC. A start request latches
// {2'b00, mode, data} into a shift register and sends it MSB first on DIN.
// The DAC samples DIN on SCLK falling edges. SYNC frames the transfer and a
// one-cycle tx_done_tick marks the return of SYNC to high.
//
// Ports:
//   clk    system clock, all logic on its rising edge
//   reset  asynchronous, active-low reset
//   bus    dac_serial_tx_if.slave: start/mode/data in; SYNC/SCLK/DIN/busy/
//          tx_done_tick out (all outputs registered)
//
// Parameters:
//   DIV_HALF      clk cycles per SCLK half-period (>=1)
//   QUIET_CYCLES  cycles of SYNC high after a frame before the next start
//                 can be accepted (>=1)
//
// States:
//   state   | meaning
//   --------+---------------------------------------------------------------
//   S_IDLE  | SYNC/SCLK high, DIN low; waiting for start
//   S_SETUP | SYNC low, SCLK high for DIV_HALF cycles, DIN = frame bit 15
//   S_SHIFT | 16 bits, each a SCLK low phase then a high phase
//   S_QUIET | SYNC high, busy still high for QUIET_CYCLES cycles
// -----------------------------------------------------------------------------
module dac_serial_tx #(
  parameter int DIV_HALF     = 2,
  parameter int QUIET_CYCLES = 4
) (
  input  logic             clk,
  input  logic             reset,
  dac_serial_tx_if.slave   bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SETUP = 2'd1,
    S_SHIFT = 2'd2,
    S_QUIET = 2'd3
  } state_t;

  // One down-counter serves both the SCLK half-period and the quiet gap,
  // so it is sized for the larger of the two reload values.
  localparam int MAXC = (DIV_HALF > QUIET_CYCLES) ? DIV_HALF : QUIET_CYCLES;
  localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;

  localparam logic [CW-1:0] DIV_LOAD   = CW'(DIV_HALF - 1);
  localparam logic [CW-1:0] QUIET_LOAD = CW'(QUIET_CYCLES - 1);

  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic [3:0]    r_bit;
  logic          r_low;
  logic [15:0]   r_shift;
  logic          r_sync;
  logic          r_sclk;
  logic          r_din;
  logic          r_busy;
  logic          r_tick;

  state_t        w_state_nxt;
  logic [CW-1:0] w_cnt_nxt;
  logic [3:0]    w_bit_nxt;
  logic          w_low_nxt;
  logic [15:0]   w_shift_nxt;
  logic          w_sync_nxt;
  logic          w_sclk_nxt;
  logic          w_din_nxt;
  logic          w_busy_nxt;
  logic          w_tick_nxt;
  logic [15:0]   w_frame;
  logic          w_cnt_zero;

  assign w_frame    = {2'b00, bus.mode, bus.data};
  assign w_cnt_zero = (r_cnt == '0);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_bit   <= '0;
      r_low   <= 1'b0;
      r_shift <= '0;
      r_sync  <= 1'b1;
      r_sclk  <= 1'b1;
      r_din   <= 1'b0;
      r_busy  <= 1'b0;
      r_tick  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_bit   <= w_bit_nxt;
      r_low   <= w_low_nxt;
      r_shift <= w_shift_nxt;
      r_sync  <= w_sync_nxt;
      r_sclk  <= w_sclk_nxt;
      r_din   <= w_din_nxt;
      r_busy  <= w_busy_nxt;
      r_tick  <= w_tick_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_bit_nxt   = r_bit;
    w_low_nxt   = r_low;
    w_shift_nxt = r_shift;
    w_sync_nxt  = r_sync;
    w_sclk_nxt  = r_sclk;
    w_din_nxt   = r_din;
    w_busy_nxt  = r_busy;
    w_tick_nxt  = 1'b0;

    case (r_state)
      S_IDLE: begin
        w_sync_nxt = 1'b1;
        w_sclk_nxt = 1'b1;
        w_din_nxt  = 1'b0;
        w_busy_nxt = 1'b0;
        if (bus.start) begin
          // mode/data are captured here only; later changes are ignored.
          w_shift_nxt = w_frame;
          w_din_nxt   = w_frame[15];
          w_sync_nxt  = 1'b0;
          w_busy_nxt  = 1'b1;
          w_cnt_nxt   = DIV_LOAD;
          w_state_nxt = S_SETUP;
        end
      end

      S_SETUP: begin
        if (w_cnt_zero) begin
          w_sclk_nxt  = 1'b0;
          w_low_nxt   = 1'b1;
          w_bit_nxt   = 4'd15;
          w_cnt_nxt   = DIV_LOAD;
          w_state_nxt = S_SHIFT;
        end else begin
          w_cnt_nxt = r_cnt - CW'(1);
        end
      end

      S_SHIFT: begin
        if (!w_cnt_zero) begin
          w_cnt_nxt = r_cnt - CW'(1);
        end else if (r_low) begin
          // Rising SCLK: move DIN on now so it has a full high phase of
          // setup before the next falling edge. The last bit is held.
          w_sclk_nxt = 1'b1;
          w_low_nxt  = 1'b0;
          w_cnt_nxt  = DIV_LOAD;
          if (r_bit != 4'd0) begin
            w_shift_nxt = {r_shift[14:0], 1'b0};
            w_din_nxt   = r_shift[14];
          end
        end else if (r_bit == 4'd0) begin
          w_sync_nxt  = 1'b1;
          w_sclk_nxt  = 1'b1;
          w_din_nxt   = 1'b0;
          w_tick_nxt  = 1'b1;
          w_cnt_nxt   = QUIET_LOAD;
          w_state_nxt = S_QUIET;
        end else begin
          w_bit_nxt  = r_bit - 4'd1;
          w_sclk_nxt = 1'b0;
          w_low_nxt  = 1'b1;
          w_cnt_nxt  = DIV_LOAD;
        end
      end

      S_QUIET: begin
        if (w_cnt_zero) begin
          w_busy_nxt  = 1'b0;
          w_state_nxt = S_IDLE;
        end else begin
          w_cnt_nxt = r_cnt - CW'(1);
        end
      end

      default: begin
        w_sync_nxt  = 1'b1;
        w_sclk_nxt  = 1'b1;
        w_din_nxt   = 1'b0;
        w_busy_nxt  = 1'b0;
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  assign bus.SYNC         = r_sync;
  assign bus.SCLK         = r_sclk;
  assign bus.DIN          = r_din;
  assign bus.busy         = r_busy;
  assign bus.tx_done_tick = r_tick;

endmodule

// File: tb/tb_dac_serial_tx.sv
module tb_dac_serial_tx;
  logic clk = 1'b0;
  logic reset;
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;

  dac_serial_tx_if bA ();
  dac_serial_tx_if bB ();

  dac_serial_tx #(.DIV_HALF(2), .QUIET_CYCLES(4)) dut_a (
    .clk   (clk),
    .reset (reset),
    .bus   (bA)
  );

  dac_serial_tx #(.DIV_HALF(1), .QUIET_CYCLES(1)) dut_b (
    .clk   (clk),
    .reset (reset),
    .bus   (bB)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Frame monitor for dut_a, sampled on the falling clk edge.
  logic        ps_a = 1'b1, psc_a = 1'b1, pb_a = 1'b0;
  logic [15:0] cap_a = '0;
  int fall_a = 0, low_a = 0, dinhi_a = 0, hi_a = 0, frames_a = 0;
  int ticks_a = 0, tick_cyc_a = 0, bfalls_a = 0, bfall_cyc_a = 0, viol_a = 0;
  logic [15:0] cap_q_a[$];
  int          gap_q_a[$];

  always @(negedge clk) begin
    ps_a  <= bA.SYNC;
    psc_a <= bA.SCLK;
    pb_a  <= bA.busy;
    if (ps_a && !bA.SYNC) begin
      low_a   <= 1;
      fall_a  <= 0;
      cap_a   <= '0;
      dinhi_a <= bA.DIN ? 1 : 0;
      gap_q_a.push_back(hi_a);
      hi_a    <= 0;
    end else if (!bA.SYNC) begin
      low_a <= low_a + 1;
      if (bA.DIN) dinhi_a <= dinhi_a + 1;
      if (psc_a && !bA.SCLK) begin
        cap_a  <= {cap_a[14:0], bA.DIN};
        fall_a <= fall_a + 1;
      end
    end
    if (bA.SYNC) hi_a <= hi_a + 1;
    if (!ps_a && bA.SYNC) begin
      cap_q_a.push_back(cap_a);
      frames_a <= frames_a + 1;
    end
    if (bA.tx_done_tick) begin
      ticks_a    <= ticks_a + 1;
      tick_cyc_a <= cyc;
    end
    if (pb_a && !bA.busy) begin
      bfalls_a    <= bfalls_a + 1;
      bfall_cyc_a <= cyc;
    end
    if (bA.SYNC && !bA.SCLK) viol_a <= viol_a + 1;
  end

  // Frame monitor for dut_b.
  logic        ps_b = 1'b1, psc_b = 1'b1, pb_b = 1'b0;
  logic [15:0] cap_b = '0;
  int fall_b = 0, low_b = 0, frames_b = 0, tick_cyc_b = 0, bfall_cyc_b = 0, viol_b = 0;

  always @(negedge clk) begin
    ps_b  <= bB.SYNC;
    psc_b <= bB.SCLK;
    pb_b  <= bB.busy;
    if (ps_b && !bB.SYNC) begin
      low_b  <= 1;
      fall_b <= 0;
      cap_b  <= '0;
    end else if (!bB.SYNC) begin
      low_b <= low_b + 1;
      if (psc_b && !bB.SCLK) begin
        cap_b  <= {cap_b[14:0], bB.DIN};
        fall_b <= fall_b + 1;
      end
    end
    if (!ps_b && bB.SYNC) frames_b <= frames_b + 1;
    if (bB.tx_done_tick) tick_cyc_b <= cyc;
    if (pb_b && !bB.busy) bfall_cyc_b <= cyc;
    if (bB.SYNC && !bB.SCLK) viol_b <= viol_b + 1;
  end

  int s0_a = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic timeout(input string tag);
    checks++;
    errors++;
    $display("FAIL %s: timeout waiting for DUT", tag);
  endtask

  task automatic pulse_a(input logic [1:0] m, input logic [11:0] d);
    @(posedge clk); #1;
    bA.mode  = m;
    bA.data  = d;
    bA.start = 1'b1;
    s0_a     = cyc;
    @(posedge clk); #1;
    bA.start = 1'b0;
  endtask

  task automatic wait_done_a(input int f0, input string tag);
    int n = 0;
    while (!((frames_a > f0) && !bA.busy) && n < 600) begin
      @(negedge clk); #1;
      n++;
    end
    if (n >= 600) timeout(tag);
  endtask

  task automatic wait_fall_a(input int target, input string tag);
    int n = 0;
    while (fall_a != target && n < 300) begin
      @(negedge clk); #1;
      n++;
    end
    if (n >= 300) timeout(tag);
  endtask

  initial begin
    int f0, t0, b0, gq, cq, n, s0_b;
    reset    = 1'b0;
    bA.start = 1'b0; bA.mode = 2'b00; bA.data = 12'h000;
    bB.start = 1'b0; bB.mode = 2'b00; bB.data = 12'h000;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_sync", 32'(bA.SYNC), 32'd1);
    chk("rst_sclk", 32'(bA.SCLK), 32'd1);
    chk("rst_din",  32'(bA.DIN),  32'd0);
    chk("rst_busy", 32'(bA.busy), 32'd0);
    chk("rst_tick", 32'(bA.tx_done_tick), 32'd0);
    @(negedge clk); #2;
    reset = 1'b1;
    repeat (3) @(negedge clk);

    // Basic frame, timing at defaults
    f0 = frames_a; t0 = ticks_a;
    pulse_a(2'b00, 12'hA5C);
    wait_done_a(f0, "t1_wait");
    chk("t1_cap",   32'(cap_a), 32'h0A5C);
    chk("t1_falls", 32'(fall_a), 32'd16);
    chk("t1_synclow", 32'(low_a), 32'd66);
    chk("t1_ticks", 32'(ticks_a - t0), 32'd1);
    chk("t1_tick_at", 32'(tick_cyc_a - s0_a), 32'd67);
    chk("t1_busy_fall", 32'(bfall_cyc_a - s0_a), 32'd71);

    // All-ones and all-zeros frames
    f0 = frames_a;
    pulse_a(2'b11, 12'hFFF);
    wait_done_a(f0, "t2a_wait");
    chk("t2_cap_3fff", 32'(cap_a), 32'h3FFF);
    f0 = frames_a;
    pulse_a(2'b00, 12'h000);
    wait_done_a(f0, "t2b_wait");
    chk("t2_cap_0000", 32'(cap_a), 32'h0000);
    chk("t2_din_high_cycles", 32'(dinhi_a), 32'd0);
    chk("t2_falls", 32'(fall_a), 32'd16);

    // Data change and start pulse mid-frame are ignored
    f0 = frames_a; b0 = bfalls_a;
    pulse_a(2'b00, 12'h123);
    wait_fall_a(8, "t3_fall8");
    bA.data  = 12'hFFF;
    bA.start = 1'b1;
    @(posedge clk); #1;
    bA.start = 1'b0;
    wait_done_a(f0, "t3_wait");
    chk("t3_cap", 32'(cap_a), 32'h0123);
    chk("t3_busy_falls", 32'(bfalls_a - b0), 32'd1);
    repeat (20) @(negedge clk);
    #1;
    chk("t3_no_second", 32'(frames_a - f0), 32'd1);
    chk("t3_sync_idle", 32'(bA.SYNC), 32'd1);

    // start held high: back-to-back frames
    f0 = frames_a; t0 = ticks_a; gq = gap_q_a.size(); cq = cap_q_a.size();
    @(posedge clk); #1;
    bA.mode = 2'b00; bA.data = 12'h800; bA.start = 1'b1;
    n = 0;
    while (frames_a < f0 + 3 && n < 1000) begin
      @(negedge clk); #1;
      n++;
    end
    if (n >= 1000) timeout("t4_frames");
    bA.start = 1'b0;
    wait_done_a(f0 + 2, "t4_wait");
    for (int i = 0; i < 3; i++) chk($sformatf("t4_cap%0d", i), 32'(cap_q_a[cq + i]), 32'h0800);
    chk("t4_gap1", 32'(gap_q_a[gq + 1]), 32'd5);
    chk("t4_gap2", 32'(gap_q_a[gq + 2]), 32'd5);
    chk("t4_ticks", 32'(ticks_a - t0), 32'd3);
    repeat (10) @(negedge clk);

    // Reset mid-frame after the 7th falling edge
    t0 = ticks_a;
    pulse_a(2'b01, 12'hABC);
    wait_fall_a(7, "t5_fall7");
    reset = 1'b0;
    #1;
    chk("t5_sync", 32'(bA.SYNC), 32'd1);
    chk("t5_sclk", 32'(bA.SCLK), 32'd1);
    chk("t5_din",  32'(bA.DIN),  32'd0);
    chk("t5_busy", 32'(bA.busy), 32'd0);
    repeat (10) @(negedge clk);
    #1;
    chk("t5_no_tick", 32'(ticks_a - t0), 32'd0);
    @(negedge clk); #2;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    f0 = frames_a;
    pulse_a(2'b00, 12'h3C3);
    wait_done_a(f0, "t5_wait");
    chk("t5_cap", 32'(cap_a), 32'h03C3);
    chk("t5_falls", 32'(fall_a), 32'd16);

    // DIV_HALF=1, QUIET_CYCLES=1 instance
    f0 = frames_b;
    @(posedge clk); #1;
    bB.mode = 2'b00; bB.data = 12'h555; bB.start = 1'b1;
    s0_b = cyc;
    @(posedge clk); #1;
    bB.start = 1'b0;
    n = 0;
    while (!((frames_b > f0) && !bB.busy) && n < 300) begin
      @(negedge clk); #1;
      n++;
    end
    if (n >= 300) timeout("t6_wait");
    chk("t6_cap", 32'(cap_b), 32'h0555);
    chk("t6_synclow", 32'(low_b), 32'd33);
    chk("t6_falls", 32'(fall_b), 32'd16);
    chk("t6_tick_at", 32'(tick_cyc_b - s0_b), 32'd34);
    chk("t6_busy_fall", 32'(bfall_cyc_b - s0_b), 32'd35);

    chk("sclk_low_while_sync_a", 32'(viol_a), 32'd0);
    chk("sclk_low_while_sync_b", 32'(viol_b), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
